// File: rtl/display_scan_ctrl_if.sv
// Load port for display_scan_ctrl: ready/valid transfer of one display word
// (one hex nibble plus one decimal point per digit).
interface display_scan_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  load_valid;
  logic                  load_ready;
  logic [4*DIGITS-1:0]   load_value;
  logic [DIGITS-1:0]     load_dp;

  modport master (
    output load_valid,
    output load_value,
    output load_dp,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_value,
    input  load_dp,
    output load_ready
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for DIGITS common-anode digits sharing one
// seven-segment decoder; new words are double-buffered and applied at frame boundaries.
module display_scan_ctrl #(
  parameter int DIGITS       = 4,
  parameter int SHOW_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 scan_en,
  input  logic                 lz_en,
  display_scan_ctrl_if.slave   load,
  output logic [3:0]           dec_in,
  output logic                 dec_decimal,
  output logic                 dec_enable,
  output logic [DIGITS-1:0]    digit_sel_n,
  output logic                 frame_start
);

  localparam int MAX_CYC = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int IDX_W   = $clog2(DIGITS);

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic [CNT_W-1:0]    cnt;

  logic [4*DIGITS-1:0] act_val;
  logic [DIGITS-1:0]   act_dp;
  logic [4*DIGITS-1:0] pend_val;
  logic [DIGITS-1:0]   pend_dp;
  logic                pend_full;

  logic [DIGITS-1:0]   supp;
  logic                tail_zero;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_supp;
  logic [DIGITS-1:0]   cur_sel_n;

  logic                blank_done;
  logic                show_done;
  logic                last_digit;
  logic                boundary;
  logic                copy;
  logic                take;

  // A digit above 0 is dark when it and every more-significant digit are blank (0, no dp).
  always_comb begin
    tail_zero = 1'b1;
    supp      = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      tail_zero = tail_zero && (act_val[4*i +: 4] == 4'h0) && !act_dp[i];
      supp[i]   = lz_en && tail_zero && (i != 0);
    end
  end

  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_supp  = 1'b0;
    cur_sel_n = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib      = act_val[4*i +: 4];
        cur_dp       = act_dp[i];
        cur_supp     = supp[i];
        cur_sel_n[i] = 1'b0;
      end
    end
  end

  assign blank_done = (cnt == BLANK_LAST);
  assign show_done  = (cnt == SHOW_LAST);
  assign last_digit = (idx == IDX_LAST);
  assign boundary   = scan_en && (state == SHOW) && show_done && last_digit;

  // Copy and capture are exclusive: capture needs an empty buffer, copy a full one.
  assign copy = pend_full && ((state == IDLE) || boundary);
  assign take = load.load_valid && !pend_full;

  assign load.load_ready = !pend_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      cnt         <= '0;
      act_val     <= '0;
      act_dp      <= '0;
      pend_val    <= '0;
      pend_dp     <= '0;
      pend_full   <= 1'b0;
      dec_in      <= 4'h0;
      dec_decimal <= 1'b0;
      dec_enable  <= 1'b0;
      digit_sel_n <= '1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;

      if (copy) begin
        act_val   <= pend_val;
        act_dp    <= pend_dp;
        pend_full <= 1'b0;
      end else if (take) begin
        pend_val  <= load.load_value;
        pend_dp   <= load.load_dp;
        pend_full <= 1'b1;
      end

      if (!scan_en) begin
        state       <= IDLE;
        idx         <= '0;
        cnt         <= '0;
        dec_in      <= 4'h0;
        dec_decimal <= 1'b0;
        dec_enable  <= 1'b0;
        digit_sel_n <= '1;
      end else begin
        case (state)
          IDLE: begin
            state       <= BLANK;
            idx         <= '0;
            cnt         <= '0;
            frame_start <= 1'b1;
            dec_in      <= 4'h0;
            dec_decimal <= 1'b0;
            dec_enable  <= 1'b0;
            digit_sel_n <= '1;
          end
          BLANK: begin
            if (blank_done) begin
              state <= SHOW;
              cnt   <= '0;
              // The active word is stable here: it only moves on the edge entering digit 0's BLANK.
              if (cur_supp) begin
                dec_in      <= 4'h0;
                dec_decimal <= 1'b0;
                dec_enable  <= 1'b0;
                digit_sel_n <= '1;
              end else begin
                dec_in      <= cur_nib;
                dec_decimal <= cur_dp;
                dec_enable  <= 1'b1;
                digit_sel_n <= cur_sel_n;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          SHOW: begin
            if (show_done) begin
              state       <= BLANK;
              cnt         <= '0;
              idx         <= last_digit ? '0 : idx + 1'b1;
              frame_start <= last_digit;
              dec_in      <= 4'h0;
              dec_decimal <= 1'b0;
              dec_enable  <= 1'b0;
              digit_sel_n <= '1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state       <= IDLE;
            idx         <= '0;
            cnt         <= '0;
            dec_in      <= 4'h0;
            dec_decimal <= 1'b0;
            dec_enable  <= 1'b0;
            digit_sel_n <= '1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized bench for display_scan_ctrl against a frame-position model
// (expected outputs derived from clock position within the frame).
module tb_display_scan_ctrl;

  localparam int DIGITS_C = 4;
  localparam int SHOW_C   = 4;
  localparam int BLANK_C  = 1;
  localparam int SLOT     = BLANK_C + SHOW_C;
  localparam int FRAME    = DIGITS_C * SLOT;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  scan_en;
  logic                  lz_en;
  logic [3:0]            dec_in;
  logic                  dec_decimal;
  logic                  dec_enable;
  logic [DIGITS_C-1:0]   digit_sel_n;
  logic                  frame_start;

  display_scan_ctrl_if #(.DIGITS(DIGITS_C)) lif ();

  display_scan_ctrl #(
    .DIGITS      (DIGITS_C),
    .SHOW_CYCLES (SHOW_C),
    .BLANK_CYCLES(BLANK_C)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scan_en    (scan_en),
    .lz_en      (lz_en),
    .load       (lif.slave),
    .dec_in     (dec_in),
    .dec_decimal(dec_decimal),
    .dec_enable (dec_enable),
    .digit_sel_n(digit_sel_n),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: running flag, position of the current clock within the frame, and the two words.
  bit                   m_run;
  int                   m_pos;
  logic [4*DIGITS_C-1:0] m_act_v, m_pend_v;
  logic [DIGITS_C-1:0]  m_act_d, m_pend_d;
  bit                   m_pf;
  bit                   m_xfer;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic bit m_supp(input int d);
    if (!lz_en || d == 0) return 1'b0;
    for (int j = d; j < DIGITS_C; j++)
      if (m_act_v[4*j +: 4] != 4'h0 || m_act_d[j]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic m_reset();
    m_run    = 1'b0;
    m_pos    = 0;
    m_act_v  = '0;
    m_act_d  = '0;
    m_pend_v = '0;
    m_pend_d = '0;
    m_pf     = 1'b0;
    m_xfer   = 1'b0;
  endtask

  task automatic m_update();
    bit bnd;
    bnd    = m_run && scan_en && (m_pos == FRAME - 1);
    m_xfer = lif.load_valid && !m_pf;
    if (m_pf && (!m_run || bnd)) begin
      m_act_v = m_pend_v;
      m_act_d = m_pend_d;
      m_pf    = 1'b0;
    end else if (m_xfer) begin
      m_pend_v = lif.load_value;
      m_pend_d = lif.load_dp;
      m_pf     = 1'b1;
    end
    if (!scan_en) begin
      m_run = 1'b0;
      m_pos = 0;
    end else if (!m_run) begin
      m_run = 1'b1;
      m_pos = 0;
    end else begin
      m_pos = (m_pos + 1) % FRAME;
    end
  endtask

  task automatic check_outputs(input string ph);
    int d;
    int w;
    bit lit;
    logic [DIGITS_C-1:0] exp_sel;
    d       = 0;
    w       = 0;
    lit     = 1'b0;
    exp_sel = '1;
    if (m_run) begin
      d   = m_pos / SLOT;
      w   = m_pos % SLOT;
      lit = (w >= BLANK_C) && !m_supp(d);
      if (lit) exp_sel[d] = 1'b0;
    end
    chk({ph, ".sel"}, 32'(digit_sel_n), 32'(exp_sel));
    chk({ph, ".en"}, 32'(dec_enable), 32'(lit));
    chk({ph, ".fs"}, 32'(frame_start), 32'(m_run && m_pos == 0));
    chk({ph, ".ready"}, 32'(lif.load_ready), 32'(!m_pf));
    if (lit) begin
      chk({ph, ".dec_in"}, 32'(dec_in), 32'(m_act_v[4*d +: 4]));
      chk({ph, ".dp"}, 32'(dec_decimal), 32'(m_act_d[d]));
    end
  endtask

  task automatic tick(input string ph);
    @(posedge clk);
    m_update();
    #1;
    check_outputs(ph);
  endtask

  task automatic load_word(input logic [15:0] v, input logic [3:0] dp, input string ph);
    bit done;
    done = 1'b0;
    lif.load_valid = 1'b1;
    lif.load_value = v;
    lif.load_dp    = dp;
    for (int k = 0; k < 2 * FRAME && !done; k++) begin
      tick(ph);
      if (m_xfer) done = 1'b1;
    end
    lif.load_valid = 1'b0;
    chk({ph, ".accepted"}, 32'(done), 32'd1);
  endtask

  task automatic wait_pos(input int pos, input string ph);
    bit found;
    found = 1'b0;
    for (int k = 0; k < FRAME + 2 && !found; k++) begin
      tick(ph);
      if (m_run && m_pos == pos) found = 1'b1;
    end
    chk({ph, ".sync"}, 32'(found), 32'd1);
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] v;
    int top;
    v   = 16'($urandom);
    top = $urandom_range(0, 4);
    for (int i = top; i < 4; i++) v[4*i +: 4] = 4'h0;
    return v;
  endfunction

  initial begin
    rst_n          = 1'b0;
    scan_en        = 1'b0;
    lz_en          = 1'b0;
    lif.load_valid = 1'b0;
    lif.load_value = '0;
    lif.load_dp    = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    chk("reset.dec_in", 32'(dec_in), 32'd0);
    chk("reset.dp", 32'(dec_decimal), 32'd0);
    #2 rst_n = 1'b1;

    // Basic scan of 0x1234
    lif.load_valid = 1'b1;
    lif.load_value = 16'h1234;
    lif.load_dp    = 4'b0000;
    tick("c1");
    lif.load_valid = 1'b0;
    tick("c1");
    scan_en = 1'b1;
    repeat (3 * FRAME) tick("c1");

    // Mid-frame load followed by a held request that must wait for the boundary
    repeat (7) tick("c2");
    load_word(16'hABCD, 4'b0000, "c2a");
    load_word(16'h5555, 4'b0000, "c2b");
    repeat (3 * FRAME) tick("c2");

    // Transfer on the exact boundary edge with an empty buffer
    wait_pos(FRAME - 1, "c3");
    lif.load_valid = 1'b1;
    lif.load_value = 16'h9876;
    lif.load_dp    = 4'b0010;
    tick("c3");
    lif.load_valid = 1'b0;
    repeat (2 * FRAME + 5) tick("c3");

    // Leading-zero suppression
    scan_en = 1'b0;
    lz_en   = 1'b1;
    tick("c4");
    load_word(16'h0050, 4'b0000, "c4a");
    tick("c4");
    scan_en = 1'b1;
    repeat (FRAME + 2) tick("c4");
    load_word(16'h0000, 4'b0000, "c4b");
    repeat (2 * FRAME) tick("c4");
    load_word(16'h0050, 4'b0100, "c4c");
    repeat (2 * FRAME) tick("c4");

    // scan_en dropped in the middle of digit 2's SHOW
    wait_pos(2 * SLOT + BLANK_C + 1, "c5");
    scan_en = 1'b0;
    tick("c5");
    tick("c5");
    scan_en = 1'b1;
    repeat (FRAME + 3) tick("c5");

    // Randomized traffic
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 199) == 0) begin
        scan_en = 1'b0;
        lz_en   = 1'($urandom_range(0, 1));
      end else if (!scan_en && $urandom_range(0, 3) == 0) begin
        scan_en = 1'b1;
      end
      if (!lif.load_valid && $urandom_range(0, 15) == 0) begin
        lif.load_valid = 1'b1;
        lif.load_value = rand_word();
        lif.load_dp    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      end
      tick("rnd");
      if (m_xfer) lif.load_valid = 1'b0;
    end
    lif.load_valid = 1'b0;
    scan_en = 1'b1;
    repeat (2 * FRAME) tick("rnd");

    // Asynchronous reset in the middle of a SHOW with the buffer full
    wait_pos(SLOT, "c6");
    load_word(16'hBEEF, 4'b1000, "c6");
    #2 rst_n = 1'b0;
    scan_en = 1'b0;
    lz_en   = 1'b0;
    m_reset();
    #1;
    check_outputs("c6_rst");
    chk("c6_rst.dec_in", 32'(dec_in), 32'd0);
    chk("c6_rst.dp", 32'(dec_decimal), 32'd0);
    #3 rst_n = 1'b1;
    repeat (3) tick("c6_idle");
    scan_en = 1'b1;
    repeat (FRAME + 2) tick("c6_run");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
